// File: rtl/alu_exec_if.sv
// rtl/alu_exec_if.sv - issue/result bundle between ID/EX issue logic and alu_exec_unit
interface alu_exec_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] fwd_ex;
    logic [XLEN-1:0] fwd_wb;
    logic [1:0]      fwd_a_sel;
    logic [1:0]      fwd_b_sel;
    logic [15:0]     imm;
    logic            use_imm;
    logic            is_beq;
    logic [XLEN-1:0] pc4;
    logic            out_valid;
    logic [XLEN-1:0] result;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic            busy;

    modport master (
        output in_valid, op, rs_val, rt_val, fwd_ex, fwd_wb, fwd_a_sel, fwd_b_sel,
               imm, use_imm, is_beq, pc4,
        input  in_ready, out_valid, result, br_taken, br_target, busy
    );

    modport slave (
        input  in_valid, op, rs_val, rt_val, fwd_ex, fwd_wb, fwd_a_sel, fwd_b_sel,
               imm, use_imm, is_beq, pc4,
        output in_ready, out_valid, result, br_taken, br_target, busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - EX-stage ALU with operand forwarding and BEQ resolution.
// Optional shift-add multiplier FSM compiled in by defining ALU_EXEC_MUL_EN.
module alu_exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_exec_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] target;
    logic            beq_hit;
    logic            in_ready;
    logic            issue;

    logic            out_valid_q;
    logic [XLEN-1:0] result_q;
    logic            br_taken_q;
    logic [XLEN-1:0] br_target_q;

    function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0]      sel,
                                                 input logic [XLEN-1:0] reg_val,
                                                 input logic [XLEN-1:0] ex_val,
                                                 input logic [XLEN-1:0] wb_val);
        case (sel)
            2'b01:   return ex_val;
            2'b10:   return wb_val;
            default: return reg_val;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] alu_calc(input logic [3:0]      f_op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        case (f_op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return $signed(a) >>> sh;
            default: return '0;
        endcase
    endfunction

    // Forwarding is resolved first so the immediate always overrides a forwarded B.
    assign imm_sext = {{(XLEN-16){bus.imm[15]}}, bus.imm};
    assign op_a     = fwd_mux(bus.fwd_a_sel, bus.rs_val, bus.fwd_ex, bus.fwd_wb);
    assign fwd_b    = fwd_mux(bus.fwd_b_sel, bus.rt_val, bus.fwd_ex, bus.fwd_wb);
    assign op_b     = bus.use_imm ? imm_sext : fwd_b;
    assign target   = bus.pc4 + (imm_sext << 2);
    assign beq_hit  = bus.is_beq && (bus.op <= OP_SRA) && (op_a == op_b);
    assign issue    = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.br_taken  = br_taken_q;
    assign bus.br_target = br_target_q;

`ifdef ALU_EXEC_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t          state;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [SHW-1:0]  cnt;
    logic [XLEN-1:0] acc_next;

    assign acc_next = mplier[0] ? (acc + mcand) : acc;
    assign in_ready = (state == S_IDLE);
    assign bus.busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    out_valid_q <= 1'b0;
                    if (issue) begin
                        br_target_q <= target;
                        if (bus.op == OP_MUL) begin
                            state      <= S_MUL;
                            br_taken_q <= 1'b0;
                            acc        <= '0;
                            mcand      <= op_a;
                            mplier     <= op_b;
                            cnt        <= '0;
                        end else begin
                            out_valid_q <= 1'b1;
                            result_q    <= alu_calc(bus.op, op_a, op_b);
                            br_taken_q  <= beq_hit;
                        end
                    end
                end
                // One multiplier bit per cycle; no early exit so latency is fixed.
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == SHW'(XLEN-1)) begin
                        state       <= S_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= acc_next;
                        br_taken_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state       <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
                default: begin
                    state       <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
`else
    assign in_ready = 1'b1;
    assign bus.busy = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
        end else begin
            out_valid_q <= issue;
            if (issue) begin
                result_q    <= alu_calc(bus.op, op_a, op_b);
                br_taken_q  <= beq_hit;
                br_target_q <= target;
            end
        end
    end
`endif
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - vector table plus scoreboard bench for alu_exec_unit
module tb_alu_exec_unit;
    localparam int XLEN = 32;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] fex;
        logic [31:0] fwb;
        logic [1:0]  asel;
        logic [1:0]  bsel;
        logic [15:0] imm;
        logic        use_imm;
        logic        is_beq;
        logic [31:0] pc4;
        logic [31:0] e_res;
        logic        e_br;
        logic [31:0] e_tgt;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        br;
        logic [31:0] tgt;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[20];
    vec_t mv;
    int   waited;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_exec_if #(.XLEN(XLEN)) bus ();
    alu_exec_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("out_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("result", bus.result, mon_e.res);
                check("br_taken", {31'b0, bus.br_taken}, {31'b0, mon_e.br});
                check("br_target", bus.br_target, mon_e.tgt);
            end
        end
    end

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] e_res);
        vec_t v;
        v = '{op, a, b, 32'h0, 32'h0, 2'b00, 2'b00, 16'h0, 1'b0, 1'b0, 32'h0, e_res, 1'b0, 32'h0};
        return v;
    endfunction

    task automatic issue(input vec_t v, input int lat, output int n);
        exp_t e;
        n = 0;
        @(posedge clk); #1;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            fails++;
            $display("FAIL issue_timeout: got in_ready 0 expected 1 (cycle %0d)", cyc);
            return;
        end
        bus.op = v.op;           bus.rs_val = v.rs;       bus.rt_val = v.rt;
        bus.fwd_ex = v.fex;      bus.fwd_wb = v.fwb;
        bus.fwd_a_sel = v.asel;  bus.fwd_b_sel = v.bsel;
        bus.imm = v.imm;         bus.use_imm = v.use_imm;
        bus.is_beq = v.is_beq;   bus.pc4 = v.pc4;
        bus.in_valid = 1'b1;
        e.res = v.e_res;
        e.br  = v.e_br;
        e.tgt = v.e_tgt;
        e.cyc = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{4'd0, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 2'b00, 2'b00, 16'h0, 1'b0, 1'b0, 32'h0, 32'h80000000, 1'b0, 32'h0};
        tbl[1]  = '{4'd0, 32'h100, 32'h200, 32'd5, 32'd7, 2'b01, 2'b10, 16'hFFFF, 1'b1, 1'b0, 32'h0, 32'd4, 1'b0, 32'hFFFFFFFC};
        tbl[2]  = '{4'd1, 32'd3, 32'd3, 32'h0, 32'h0, 2'b00, 2'b00, 16'hFFFE, 1'b0, 1'b1, 32'h100, 32'h0, 1'b1, 32'hF8};
        tbl[3]  = '{4'd1, 32'd3, 32'd4, 32'h0, 32'h0, 2'b00, 2'b00, 16'hFFFE, 1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, 1'b0, 32'hF8};
        tbl[4]  = '{4'd8, 32'h80000000, 32'd31, 32'h0, 32'h0, 2'b00, 2'b00, 16'h0, 1'b0, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b0, 32'h0};
        tbl[5]  = '{4'd5, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 16'h0, 1'b0, 1'b0, 32'h0, 32'h1, 1'b0, 32'h0};
        tbl[6]  = '{4'd5, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 2'b00, 2'b00, 16'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
        tbl[7]  = '{4'd6, 32'h1, 32'h21, 32'h0, 32'h0, 2'b00, 2'b00, 16'h0, 1'b0, 1'b0, 32'h0, 32'h2, 1'b0, 32'h0};
        tbl[8]  = '{4'd7, 32'h80000000, 32'h4, 32'h0, 32'h0, 2'b00, 2'b00, 16'h0, 1'b0, 1'b0, 32'h0, 32'h08000000, 1'b0, 32'h0};
        tbl[9]  = '{4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0, 2'b00, 2'b00, 16'h0, 1'b0, 1'b0, 32'h0, 32'hF000F000, 1'b0, 32'h0};
        tbl[10] = '{4'd3, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0, 2'b00, 2'b00, 16'h0, 1'b0, 1'b0, 32'h0, 32'hFFF0FFF0, 1'b0, 32'h0};
        tbl[11] = '{4'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0, 2'b00, 2'b00, 16'h0, 1'b0, 1'b0, 32'h0, 32'h0FF00FF0, 1'b0, 32'h0};
        tbl[12] = '{4'd12, 32'd5, 32'd5, 32'h0, 32'h0, 2'b00, 2'b00, 16'h4, 1'b0, 1'b1, 32'h200, 32'h0, 1'b0, 32'h210};
        tbl[13] = '{4'd1, 32'h0, 32'h1, 32'h0, 32'h0, 2'b00, 2'b00, 16'h0, 1'b0, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b0, 32'h0};
        tbl[14] = '{4'd0, 32'h10, 32'h55, 32'h99, 32'h0, 2'b11, 2'b01, 16'h0, 1'b0, 1'b0, 32'h0, 32'hA9, 1'b0, 32'h0};
        tbl[15] = '{4'd4, 32'h1, 32'h2, 32'h0, 32'h20, 2'b10, 2'b10, 16'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
        tbl[16] = '{4'd0, 32'h1, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 16'h7FFF, 1'b1, 1'b0, 32'h0, 32'h8000, 1'b0, 32'h1FFFC};
        tbl[17] = '{4'd2, 32'h0, 32'h9, 32'h9, 32'h0, 2'b01, 2'b00, 16'h1, 1'b0, 1'b1, 32'h40, 32'h9, 1'b1, 32'h44};
        tbl[18] = '{4'd5, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 16'hFFFF, 1'b1, 1'b0, 32'h0, 32'h1, 1'b0, 32'hFFFFFFFC};
        tbl[19] = '{4'd8, 32'h80000001, 32'h20, 32'h0, 32'h0, 2'b00, 2'b00, 16'h0, 1'b0, 1'b0, 32'h0, 32'h80000001, 1'b0, 32'h0};

        rst_n = 1'b0;
        bus.in_valid = 1'b0;  bus.op = 4'd0;  bus.rs_val = '0;  bus.rt_val = '0;
        bus.fwd_ex = '0;      bus.fwd_wb = '0; bus.fwd_a_sel = 2'b00; bus.fwd_b_sel = 2'b00;
        bus.imm = 16'h0;      bus.use_imm = 1'b0; bus.is_beq = 1'b0; bus.pc4 = '0;
        #3;
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        check("rst_result", bus.result, 32'h0);
        check("rst_br_taken", {31'b0, bus.br_taken}, 32'h0);
        check("rst_br_target", bus.br_target, 32'h0);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", {31'b0, bus.in_ready}, 32'h1);

        for (int i = 0; i < 20; i++) issue(tbl[i], 1, waited);
        idle();
        repeat (3) @(posedge clk);

`ifdef ALU_EXEC_MUL_EN
        issue(mk(4'd9, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD), 33, waited);
        idle();
        check("mul_busy", {31'b0, bus.busy}, 32'h1);
        waited = 0;
        while (bus.in_ready === 1'b0 && waited < 100) begin
            waited++;
            @(posedge clk); #1;
        end
        check("mul_ready_low_cycles", 32'(waited), 32'd33);

        issue(mk(4'd9, 32'h0, 32'hDEADBEEF, 32'h0), 33, waited);
        issue(mk(4'd9, 32'h1, 32'h12345678, 32'h12345678), 33, waited);
        check("mul_reissue_wait", 32'(waited), 32'd33);
        issue(mk(4'd9, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1), 33, waited);
        mv = mk(4'd9, 32'd5, 32'd5, 32'h19);
        mv.is_beq = 1'b1;
        mv.pc4 = 32'h10;
        mv.e_tgt = 32'h10;
        issue(mv, 33, waited);
        issue(tbl[0], 1, waited);
        check("add_after_mul_wait", 32'(waited), 32'd33);
        idle();
        repeat (3) @(posedge clk);

        issue(mk(4'd9, 32'h7, 32'h9, 32'h3F), 33, waited);
        idle();
        repeat (9) @(posedge clk);
`else
        issue(mk(4'd9, 32'hFFFFFFFF, 32'd3, 32'h0), 1, waited);
        idle();
        check("nomul_ready", {31'b0, bus.in_ready}, 32'h1);
        check("nomul_busy", {31'b0, bus.busy}, 32'h0);
        mv = mk(4'd0, 32'd1, 32'd2, 32'd3);
        mv.pc4 = 32'h40;
        mv.e_tgt = 32'h40;
        issue(mv, 1, waited);
        idle();
        repeat (2) @(posedge clk);
`endif
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        check("arst_result", bus.result, 32'h0);
        check("arst_br_taken", {31'b0, bus.br_taken}, 32'h0);
        check("arst_br_target", bus.br_target, 32'h0);
        check("arst_busy", {31'b0, bus.busy}, 32'h0);
        check("arst_in_ready", {31'b0, bus.in_ready}, 32'h1);
`ifdef ALU_EXEC_MUL_EN
        if (sb.size() > 0) void'(sb.pop_back());
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("after_abort_in_ready", {31'b0, bus.in_ready}, 32'h1);

        issue(tbl[5], 1, waited);
        issue(tbl[2], 1, waited);
        idle();
        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
